// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one memory read at a time from pc and holds
// the returned word for the control unit until it is accepted or squashed by a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [6:0]  opcode,
    output logic [31:0] pc_out,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // One-hot so mem_read and instr_valid decode from a single flop each.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        REQ   = 3'b010,
        VALID = 3'b100
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        kill;
    logic [31:0] redirect_target;
    logic        handshake;
    logic        capture;

    assign redirect_target = {pc_next[31:2], 2'b00};
    assign handshake       = (state == VALID) && instr_ready;
    assign capture         = (state == REQ) && mem_ack && !kill && !pc_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!pc_write) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next = capture ? VALID : IDLE;
                end
            end
            VALID: begin
                if (pc_write || instr_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = state[1];
        instr_valid = state[2];
        opcode      = instruction[6:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VECTOR;
            mem_addr    <= RESET_VECTOR;
            kill        <= 1'b0;
            instruction <= NOP;
            pc_out      <= RESET_VECTOR;
            fetch_count <= 32'd0;
        end else begin
            if ((state == IDLE) && !pc_write) begin
                mem_addr <= pc;
            end

            if (pc_write) begin
                pc <= redirect_target;
            end else if (handshake) begin
                pc <= pc + 32'd4;
            end

            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end

            // A redirect while a read is in flight cannot cancel the bus cycle,
            // so remember to throw the response away when it arrives.
            if (state == REQ) begin
                if (mem_ack) begin
                    kill <= 1'b0;
                end else if (pc_write) begin
                    kill <= 1'b1;
                end
            end

            if (capture) begin
                instruction <= mem_rdata;
                pc_out      <= mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random
// traffic, all continuously compared against a transaction-level model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [31:0] pc_out;
    logic        pc_write;
    logic [31:0] pc_next;
    logic [31:0] fetch_count;

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .pc_write    (pc_write),
        .pc_next     (pc_next),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: the next fetch address, the one outstanding read (if any) and
    // whether its answer is still wanted, and the instruction being offered.
    logic [31:0] m_pc;
    logic        m_busy;
    logic [31:0] m_addr;
    logic        m_stale;
    logic        m_have;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_busy  = 1'b0;
        m_addr  = 32'h0;
        m_stale = 1'b0;
        m_have  = 1'b0;
        m_instr = 32'h0000_0013;
        m_ipc   = 32'h0;
        m_count = 32'h0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            if (mem_ack) begin
                m_busy = 1'b0;
                if (!m_stale && !pc_write) begin
                    m_have  = 1'b1;
                    m_instr = mem_rdata;
                    m_ipc   = m_addr;
                end
                m_stale = 1'b0;
            end else if (pc_write) begin
                m_stale = 1'b1;
            end
        end else if (m_have) begin
            if (instr_ready) begin
                m_count = m_count + 1;
                m_pc    = m_pc + 4;
                m_have  = 1'b0;
            end
            if (pc_write) m_have = 1'b0;
        end else if (!pc_write) begin
            m_busy = 1'b1;
            m_addr = m_pc;
        end
        if (pc_write) m_pc = pc_next & 32'hFFFF_FFFC;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model mem_read", {31'd0, mem_read}, {31'd0, m_busy});
            chk("model mem_addr", mem_addr, m_addr);
            chk("model instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
            chk("model instruction", instruction, m_instr);
            chk("model opcode", {25'd0, opcode}, {25'd0, m_instr[6:0]});
            chk("model pc_out", pc_out, m_ipc);
            chk("model fetch_count", fetch_count, m_count);
        end
    end

    task automatic step(input logic a, input logic [31:0] rd, input logic rdy,
                        input logic pw, input logic [31:0] pn);
        mem_ack     = a;
        mem_rdata   = rd;
        instr_ready = rdy;
        pc_write    = pw;
        pc_next     = pn;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0; mem_rdata = 32'h0; instr_ready = 1'b0;
        pc_write = 1'b0; pc_next = 32'h0;
        model_reset();
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset instruction", instruction, 32'h0000_0013);
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset fetch_count", fetch_count, 32'h0);

        // First fetch with an immediate ack.
        reset = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("first req mem_read", {31'd0, mem_read}, 32'd1);
        chk("first req addr", mem_addr, 32'h0);
        step(1, 32'h0050_0093, 0, 0, 0);
        chk("first valid", {31'd0, instr_valid}, 32'd1);
        chk("first opcode", {25'd0, opcode}, 32'h13);
        chk("first pc_out", pc_out, 32'h0);

        // Three back-to-back handshakes.
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("b2b req addr 4", mem_addr, 32'h4);
        step(1, 32'h0000_0113, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("b2b req addr 8", mem_addr, 32'h8);
        step(1, 32'h0000_0193, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("b2b fetch_count", fetch_count, 32'd3);

        // Redirect in IDLE back to 8 leaves the count alone.
        step(0, 0, 0, 1, 32'h0000_0009);
        chk("idle redirect count", fetch_count, 32'd3);
        step(0, 0, 0, 0, 0);
        chk("idle redirect addr", mem_addr, 32'h8);
        step(1, 32'hDEAD_BE33, 0, 0, 0);

        // Stall for five cycles; stray acks must be ignored.
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h1234_5678, 0, 0, 0);
            chk("stall no read", {31'd0, mem_read}, 32'd0);
            chk("stall instruction", instruction, 32'hDEAD_BE33);
            chk("stall pc_out", pc_out, 32'h8);
            chk("stall count", fetch_count, 32'd3);
        end

        // Redirect coincident with handshake.
        step(0, 0, 1, 1, 32'h0000_0040);
        chk("hs redirect count", fetch_count, 32'd4);
        step(0, 0, 0, 0, 0);
        chk("hs redirect addr", mem_addr, 32'h40);

        // Redirect while a read is in flight; the late response is discarded.
        step(0, 0, 0, 1, 32'h0000_0102);
        chk("kill hold addr", mem_addr, 32'h40);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("kill hold read", {31'd0, mem_read}, 32'd1);
        step(1, 32'hBAD0_0001, 0, 0, 0);
        chk("kill discarded", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("kill next addr", mem_addr, 32'h100);

        // Reset during a request with a coincident ack.
        reset = 1'b1;
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        chk("rst req valid", {31'd0, instr_valid}, 32'd0);
        chk("rst req instruction", instruction, 32'h0000_0013);
        reset = 1'b0;
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        chk("rst req next addr", mem_addr, 32'h0);
        chk("rst idle ack ignored", {31'd0, instr_valid}, 32'd0);

        // PC wraps from the top of the address space.
        step(1, 32'h0000_0033, 0, 0, 0);
        step(0, 0, 1, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0, 0);
        chk("wrap addr top", mem_addr, 32'hFFFF_FFFC);
        step(1, 32'h0000_0063, 0, 0, 0);
        chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("wrap addr zero", mem_addr, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 ($urandom_range(0, 7) == 0), $urandom);
        end
        reset = 1'b0;

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_read  output  1  instruction-memory read request, registered.
REQ-005 mem_addr  output  32  request address; SHALL hold constant while mem_read=1.
REQ-006 mem_ack  input  1  memory response strobe; mem_rdata is valid in the same cycle.
REQ-007 mem_rdata  input  32  instruction word from memory.
REQ-008 instr_valid  output  1  instruction register holds a live instruction for the control unit.
REQ-009 instr_ready  input  1  control unit accepts the current instruction.
REQ-010 instruction  output  32  instruction register contents.
REQ-011 opcode  output  7  instruction[6:0], driven to the control unit's instruction-opcode input.
REQ-012 pc_out  output  32  address of the instruction currently in the instruction register.
REQ-013 pc_write  input  1  redirect strobe from branch/jump resolution.
REQ-014 pc_next  input  32  redirect target, sampled only when pc_write=1.
REQ-015 fetch_count  output  32  number of instructions accepted since reset.

Function
REQ-016 States SHALL be IDLE, REQ and VALID, plus one kill flag.
REQ-017 IDLE SHALL go to REQ on the next edge, latching mem_addr<=pc and setting mem_read<=1.
REQ-018 REQ: mem_read SHALL stay 1 until the edge at which mem_ack=1.
REQ-019 REQ with mem_ack=1 and kill=0 and no redirect: instruction<=mem_rdata, pc_out<=mem_addr, mem_read<=0, go VALID.
REQ-020 Minimum latency: mem_ack in the first REQ cycle SHALL give instr_valid=1 on the following cycle.
REQ-021 VALID: instr_valid=1, and instruction, opcode and pc_out SHALL hold stable until handshake or redirect.
REQ-022 VALID with instr_valid=1 and instr_ready=1 at an edge (handshake):
- pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- fetch_count<=fetch_count+1, wrapping.
- go IDLE; instr_valid=0 next cycle.
REQ-023 Redirect (pc_write=1) SHALL have priority over all other events: pc<={pc_next[31:2],2'b00}; low two bits always forced to zero.
REQ-024 Redirect in IDLE or VALID:
- go IDLE and drop the instruction register.
- instr_valid=0 next cycle; fetch_count unchanged.
REQ-025 Redirect in REQ with mem_ack=0: stay in REQ, keep mem_addr/mem_read unchanged, set kill=1.
REQ-026 REQ with mem_ack=1 and (kill=1 or pc_write=1): discard mem_rdata, clear kill, mem_read<=0, go IDLE; the next request SHALL use the updated pc.
REQ-027 Redirect coincident with handshake: the target SHALL win over pc+4; fetch_count SHALL still increment.
REQ-028 mem_ack outside REQ SHALL be ignored.
REQ-029 opcode SHALL be purely combinational from the instruction register.

Reset
REQ-030 Reset SHALL take effect from any state, including mid-request, on the edge where reset=1.
REQ-031 Reset values: state=IDLE, pc=RESET_VECTOR, mem_read=0, mem_addr=RESET_VECTOR, kill=0, instr_valid=0, instruction=32'h0000_0013 (NOP), pc_out=RESET_VECTOR, fetch_count=0.
REQ-032 A response pending at reset SHALL NOT be captured; an ack arriving in IDLE after reset is ignored.

Verification
REQ-033 Reset release, mem_ack=1 on the first REQ cycle with rdata=32'h00500093 -> mem_addr=0, instr_valid=1 one cycle later, opcode=7'h13, pc_out=0.
REQ-034 Three back-to-back handshakes with instr_ready tied to 1 -> request addresses 0, 4, 8; fetch_count=3.
REQ-035 VALID with instr_ready=0 for 5 cycles -> instruction/pc_out stable, no new mem_read; fetch_count unchanged.
REQ-036 pc_write=1, pc_next=32'h0000_0102 in REQ, ack delayed 3 cycles:
- mem_addr unchanged during wait; response discarded.
- next request at 32'h0000_0100.
REQ-037 pc_write=1 in the same cycle as the handshake at pc=8, pc_next=32'h40 -> next request at 32'h40; fetch_count incremented.
REQ-038 reset=1 during REQ with mem_ack=1 in the same cycle -> instr_valid=0, instruction=32'h00000013, next request at RESET_VECTOR.
